// File: rtl/store_commit_buffer_if.sv
// Bus bundle for store_commit_buffer: ROB commit port, data-cache write port,
// load forwarding lookup and status. slave = buffer side, master = environment.
interface store_commit_buffer_if;
   logic        commit_we;
   logic [31:0] commit_addr;
   logic [31:0] commit_data;
   logic [1:0]  commit_size;
   logic        commit_ready;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_mask;
   logic        mem_ack;
   logic [31:0] ld_addr;
   logic        ld_fwd_hit;
   logic [3:0]  ld_fwd_mask;
   logic [31:0] ld_fwd_data;
   logic        drained;
   logic        err_sticky;

   modport slave (
      input  commit_we, commit_addr, commit_data, commit_size, mem_ack, ld_addr,
      output commit_ready, mem_req, mem_addr, mem_data, mem_mask,
             ld_fwd_hit, ld_fwd_mask, ld_fwd_data, drained, err_sticky
   );

   modport master (
      output commit_we, commit_addr, commit_data, commit_size, mem_ack, ld_addr,
      input  commit_ready, mem_req, mem_addr, mem_data, mem_mask,
             ld_fwd_hit, ld_fwd_mask, ld_fwd_data, drained, err_sticky
   );
endinterface

// File: rtl/store_commit_buffer.sv
// FIFO of committed stores feeding the D-cache write port, with byte-granular
// load forwarding. Define STORE_COALESCE_EN to merge same-word pushes into the youngest entry.
module store_commit_buffer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input logic                  clk,
   input logic                  rst,
   store_commit_buffer_if.slave sb
);
   typedef enum logic {IDLE, REQ} state_t;

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] data;
      logic [3:0]  mask;
   } entry_t;

   entry_t            ent_q [DEPTH];
   entry_t            ent_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_idx, fwd_idx;
   logic [PTR_W:0]    count_q, count_d;
   state_t            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic [31:0]       mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
   logic [3:0]        mem_mask_q, mem_mask_d;
   logic              err_q, err_d;

   logic        legal, has_space, coal_ok, push_ok, alloc, merge, pop;
   logic [3:0]  push_mask, fwd_mask;
   logic [31:0] push_data, fwd_data;
   entry_t      merged, head;
   logic        unused_ld;

   assign unused_ld = ^sb.ld_addr[1:0];

   // Lane placement and alignment legality of the incoming store
   always_comb begin
      legal     = 1'b0;
      push_mask = 4'b0000;
      push_data = sb.commit_data;
      case (sb.commit_size)
         2'd0: begin
            legal     = 1'b1;
            push_mask = 4'b0001 << sb.commit_addr[1:0];
            push_data = {4{sb.commit_data[7:0]}};
         end
         2'd1: begin
            legal     = ~sb.commit_addr[0];
            push_mask = sb.commit_addr[1] ? 4'b1100 : 4'b0011;
            push_data = {2{sb.commit_data[15:0]}};
         end
         2'd2: begin
            legal     = (sb.commit_addr[1:0] == 2'b00);
            push_mask = 4'b1111;
         end
         default: legal = 1'b0;
      endcase
   end

   assign tail_idx  = wr_ptr_q - PTR_W'(1);
   assign has_space = count_q < (PTR_W+1)'(DEPTH);

`ifdef STORE_COALESCE_EN
   // Never merge into the head once its request is on the bus
   assign coal_ok = (count_q != '0) && (ent_q[tail_idx].waddr == sb.commit_addr[31:2]) &&
                    !((count_q == (PTR_W+1)'(1)) && (state_q == REQ));
`else
   assign coal_ok = 1'b0;
`endif

   assign push_ok = sb.commit_we && legal && (has_space || coal_ok);
   assign merge   = push_ok && coal_ok;
   assign alloc   = push_ok && !coal_ok;
   assign pop     = (state_q == REQ) && sb.mem_ack;

   always_comb begin
      merged       = ent_q[tail_idx];
      merged.mask  = ent_q[tail_idx].mask | push_mask;
      for (int b = 0; b < 4; b++)
         if (push_mask[b]) merged.data[8*b +: 8] = push_data[8*b +: 8];
   end

   // A merge into the head in the same cycle it is launched must reach the bus
   assign head = (merge && (tail_idx == rd_ptr_q)) ? merged : ent_q[rd_ptr_q];

   always_comb begin
      ent_d = ent_q;
      if (alloc) ent_d[wr_ptr_q] = '{waddr: sb.commit_addr[31:2], data: push_data, mask: push_mask};
      if (merge) ent_d[tail_idx] = merged;
      wr_ptr_d = alloc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({alloc, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
      err_d = err_q | (sb.commit_we && (!(has_space || coal_ok) || !legal));
   end

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_mask_d = mem_mask_q;
      case (state_q)
         IDLE: if (count_q != '0) begin
            mem_req_d  = 1'b1;
            mem_addr_d = {head.waddr, 2'b00};
            mem_data_d = head.data;
            mem_mask_d = head.mask;
            state_d    = REQ;
         end
         REQ: if (sb.mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Forwarding: walk oldest to youngest so younger bytes overwrite older ones
   always_comb begin
      fwd_mask = 4'b0000;
      fwd_data = '0;
      fwd_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PTR_W'(i);
         if (((PTR_W+1)'(i) < count_q) && (ent_q[fwd_idx].waddr == sb.ld_addr[31:2]))
            for (int b = 0; b < 4; b++)
               if (ent_q[fwd_idx].mask[b]) begin
                  fwd_data[8*b +: 8] = ent_q[fwd_idx].data[8*b +: 8];
                  fwd_mask[b]        = 1'b1;
               end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_mask_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_mask_q <= mem_mask_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk) ent_q <= ent_d;

   assign sb.commit_ready = has_space || coal_ok;
   assign sb.mem_req      = mem_req_q;
   assign sb.mem_addr     = mem_addr_q;
   assign sb.mem_data     = mem_data_q;
   assign sb.mem_mask     = mem_mask_q;
   assign sb.ld_fwd_hit   = (fwd_mask != 4'b0000);
   assign sb.ld_fwd_mask  = fwd_mask;
   assign sb.ld_fwd_data  = fwd_data;
   assign sb.drained      = (count_q == '0) && (state_q == IDLE);
   assign sb.err_sticky   = err_q;
endmodule

// File: tb/tb_store_commit_buffer.sv
// Randomized scoreboard bench for store_commit_buffer: a queue-based store model
// predicts cache writes, forwarding, readiness and error state.
module tb_store_commit_buffer;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   store_commit_buffer_if bus ();

   store_commit_buffer #(.DEPTH(DEPTH), .PTR_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (bus.slave)
   );

   typedef struct {
      logic [29:0] w;
      logic [31:0] d;
      logic [3:0]  m;
   } st_t;

   st_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   bit  req_exp = 1'b0;
   bit  err_exp = 1'b0;
   bit  pend_v = 1'b0, pend_merge = 1'b0, pend_err = 1'b0;
   bit  done = 1'b0;
   st_t pend;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit coal_match(input logic [31:0] a);
`ifdef STORE_COALESCE_EN
      return (exp_q.size() > 0) && (exp_q[$].w == a[31:2]) && !((exp_q.size() == 1) && req_exp);
`else
      return 1'b0;
`endif
   endfunction

   // Apply the push decided for the cycle that just ended at this edge
   task automatic apply_pending();
      st_t t;
      if (pend_v) begin
         if (pend_merge) begin
            t = exp_q[$];
            for (int b = 0; b < 4; b++)
               if (pend.m[b]) t.d[8*b +: 8] = pend.d[8*b +: 8];
            t.m = t.m | pend.m;
            exp_q[$] = t;
         end else exp_q.push_back(pend);
      end
      if (pend_err) err_exp = 1'b1;
      pend_v = 1'b0;
      pend_err = 1'b0;
   endtask

   task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit ack, input logic [31:0] la);
      bit   legal, rdy;
      logic [3:0]  m;
      logic [31:0] ld;
      @(posedge clk);
      apply_pending();
      #1;
      bus.commit_we   = we;
      bus.commit_addr = a;
      bus.commit_data = d;
      bus.commit_size = sz;
      bus.mem_ack     = ack;
      bus.ld_addr     = la;
      if (we) begin
         legal = 1'b1;
         m  = 4'b1111;
         ld = d;
         if (sz == 2'd0) begin
            m  = 4'b0001 << a[1:0];
            ld = {4{d[7:0]}};
         end else if (sz == 2'd1) begin
            legal = (a[0] == 1'b0);
            m  = a[1] ? 4'b1100 : 4'b0011;
            ld = {2{d[15:0]}};
         end else if (sz == 2'd2) legal = (a[1:0] == 2'b00);
         else legal = 1'b0;
         rdy = (exp_q.size() < DEPTH) || coal_match(a);
         if (!legal || !rdy) pend_err = 1'b1;
         else begin
            pend_v     = 1'b1;
            pend_merge = coal_match(a);
            pend       = '{w: a[31:2], d: ld, m: m};
         end
      end
   endtask

   task automatic idle(input int n, input bit ack, input logic [31:0] la);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 2'd0, ack, la);
   endtask

   task automatic do_reset();
      @(posedge clk);
      apply_pending();
      #1;
      rst = 1'b1;
      bus.commit_we = 1'b0;
      bus.mem_ack   = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: compares every cycle, pops the scoreboard on each accepted request
   always @(negedge clk) begin
      logic [3:0]  fm;
      logic [31:0] fd;
      st_t e;
      if (!done) begin
         if (rst) begin
            exp_q.delete();
            req_exp = 1'b0;
            err_exp = 1'b0;
         end else begin
            chk("commit_ready", bus.commit_ready, (exp_q.size() < DEPTH) || coal_match(bus.commit_addr));
            chk("mem_req", bus.mem_req, req_exp);
            chk("drained", bus.drained, (exp_q.size() == 0) && !req_exp);
            chk("err_sticky", bus.err_sticky, err_exp);
            fm = 4'b0000;
            fd = 32'h0;
            foreach (exp_q[i])
               if (exp_q[i].w == bus.ld_addr[31:2])
                  for (int b = 0; b < 4; b++)
                     if (exp_q[i].m[b]) begin
                        fd[8*b +: 8] = exp_q[i].d[8*b +: 8];
                        fm[b] = 1'b1;
                     end
            chk("fwd_hit", bus.ld_fwd_hit, fm != 4'b0000);
            chk("fwd_mask", bus.ld_fwd_mask, fm);
            chk("fwd_data", bus.ld_fwd_data, fd);
            if (req_exp) begin
               if (exp_q.size() == 0) chk("req_without_store", 1, 0);
               else begin
                  e = exp_q[0];
                  chk("mem_addr", bus.mem_addr, {e.w, 2'b00});
                  chk("mem_data", bus.mem_data, e.d);
                  chk("mem_mask", bus.mem_mask, e.m);
                  if (bus.mem_ack) void'(exp_q.pop_front());
               end
               if (bus.mem_ack) req_exp = 1'b0;
            end else if (exp_q.size() > 0) req_exp = 1'b1;
         end
      end
   end

   initial begin
      logic [31:0] wpool [4];
      bus.commit_we = 1'b0; bus.commit_addr = '0; bus.commit_data = '0;
      bus.commit_size = '0; bus.mem_ack = 1'b0; bus.ld_addr = '0;
      wpool = '{32'h700, 32'h704, 32'h708, 32'h70C};
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_data", bus.mem_data, 32'h0);
      chk("rst_mem_mask", bus.mem_mask, 32'h0);

      // Single word store with ack tied high
      step(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b1, 32'h100);
      idle(4, 1'b1, 32'h100);
      // Byte store held for 10 cycles before ack
      step(1'b1, 32'h203, 32'h5A, 2'd0, 1'b0, 32'h200);
      idle(10, 1'b0, 32'h200);
      idle(3, 1'b1, 32'h200);
      // Fill past capacity with ack held low, then drain in order
      for (int i = 0; i < 9; i++)
         step(1'b1, 32'h600 + 32'(4*i), $urandom, 2'd2, 1'b0, 32'h600 + 32'(4*(i%3)));
      idle(20, 1'b1, 32'h604);
      // Forwarding merge of a byte over a word
      step(1'b1, 32'h300, 32'h11223344, 2'd2, 1'b0, 32'h302);
      step(1'b1, 32'h301, 32'hAA, 2'd0, 1'b0, 32'h302);
      step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h302);
      @(negedge clk);
      chk("fwd_merge_data", bus.ld_fwd_data, 32'h1122AA44);
      chk("fwd_merge_mask", bus.ld_fwd_mask, 32'hF);
      idle(6, 1'b1, 32'h300);
      // Misaligned halfword, then reset clears the error
      step(1'b1, 32'h401, 32'hBEEF, 2'd1, 1'b0, 32'h400);
      idle(2, 1'b0, 32'h400);
      do_reset();
      // Same-word pushes (merge only in the coalescing build)
      step(1'b1, 32'h500, 32'hCAFEF00D, 2'd2, 1'b0, 32'h504);
      step(1'b1, 32'h504, 32'h12, 2'd0, 1'b0, 32'h504);
      step(1'b1, 32'h505, 32'h34, 2'd0, 1'b0, 32'h504);
      idle(3, 1'b0, 32'h504);
      idle(8, 1'b1, 32'h504);

      for (int c = 0; c < 800; c++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         bit          ack;
         if (c == 400) do_reset();
         a   = wpool[$urandom_range(3)] + 32'($urandom_range(3));
         sz  = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
         ack = ((c / 100) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
         step($urandom_range(2) != 0, a, $urandom, sz, ack, wpool[$urandom_range(3)] + 32'($urandom_range(3)));
      end

      idle(40, 1'b1, 32'h700);
      @(negedge clk);
      chk("final_empty", exp_q.size(), 0);
      chk("final_drained", bus.drained, 1);
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
